instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch stage placed directly upstream of the 64-word combinational instruction ROM. It holds the program counter and drives the ROM word address. It captures the returned instruction into an IF/ID pipeline register with valid, stall and flush control. It accepts redirects from the branch/jump resolution logic and faults on illegal fetch addresses.

Parameters:
ADDR_W, 6, ROM word-address width; ROM covers byte range 0 .. 4*2^ADDR_W-1
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on reset or flush (matches ROM default/nop word)
CNT_W, 16, width of fetch counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  ADDR_W  ROM word address, combinational = pc[ADDR_W+1:2]
rom_dout  in  32  ROM instruction, combinational response to rom_addr (same cycle)
stall  in  1  decode stage cannot accept; hold PC and IF/ID
redirect  in  1  taken branch/jump this cycle
redirect_pc  in  32  byte target for redirect
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  fetched instruction
if_id_pc  out  32  byte address of if_id_instr
if_id_pc4  out  32  if_id_pc + 4 (link value for jal/jalr)
pc  out  32  current fetch PC
fault  out  1  sticky fetch fault
fault_pc  out  32  offending address captured at fault
fetch_count  out  CNT_W  saturating count of instructions delivered to IF/ID

Behaviour:
- States: BOOT, RUN, FAULT. Reset enters BOOT.
- Reset values, applied asynchronously: pc=RESET_PC; if_id_valid=0; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc4=0; fault=0; fault_pc=0; fetch_count=0.
- BOOT: lasts exactly one cycle with no capture and pc unchanged, then moves to RUN. This gives the first fetch a clean cycle after reset deassertion.
- RUN, per rising edge, in priority order:
  1. redirect=1 (takes priority over stall):
     - If redirect_pc[1:0]!=0 or redirect_pc >= 4*2^ADDR_W: go to FAULT; fault<=1; fault_pc<=redirect_pc; pc unchanged; if_id_valid<=0; if_id_instr<=NOP_INSTR.
     - Otherwise: pc<=redirect_pc; if_id_valid<=0; if_id_instr<=NOP_INSTR (flush). if_id_pc and if_id_pc4 hold. Redirect latency: the target instruction appears in IF/ID on the edge after the redirect edge.
  2. stall=1, no redirect: pc and all IF/ID fields hold; fetch_count holds.
  3. Otherwise: if_id_instr<=rom_dout; if_id_pc<=pc; if_id_pc4<=pc+4; if_id_valid<=1; pc<=pc+4; fetch_count increments, saturating at all-ones.
     - If the pc+4 result would be >= 4*2^ADDR_W: still deliver the current instruction, then on the next edge go to FAULT with fault_pc=pc+4 and if_id_valid<=0.
     - pc never silently wraps into ROM word 0.
- FAULT: pc, fault_pc and fetch_count frozen; if_id_valid=0; if_id_instr=NOP_INSTR; stall and redirect ignored. FAULT is left only by reset.
- Arithmetic: all PC arithmetic is 32-bit unsigned. The range check is performed on the full 32 bits, not the truncated rom_addr.
- rom_addr follows pc at all times, including BOOT and FAULT; no ROM side effects.
- Reset mid-operation: every register returns to its reset value immediately; the BOOT cycle repeats after release.

Test Plan:
- Reset, then run with stall=0, ROM loaded with the team test program.
  - Edge 2 after reset release: if_id_valid=1, instr=32'h0000_3f37, if_id_pc=0, if_id_pc4=4.
  - Next edge: instr=32'h0200_0fe7, if_id_pc=4.
- Redirect to the jalr target: assert redirect=1 with redirect_pc=32'h20 while pc=8.
  - Next edge: if_id_valid=0, instr=NOP_INSTR, pc=32'h20.
  - Following edge: instr=32'h0000_1c63, if_id_pc=32'h20, if_id_pc4=32'h24.
- Stall: stall=1 for 3 cycles at pc=32'h24.
  - IF/ID, pc and fetch_count are unchanged throughout.
  - Release: instr=32'h042f_0293, if_id_pc=32'h24.
- Simultaneous stall=1 and redirect=1 with redirect_pc=32'h08: the redirect wins; pc=8 and IF/ID is flushed.
- Fault cases:
  - redirect_pc=32'h22 -> fault=1, fault_pc=32'h22, if_id_valid stays 0 with later stimulus ignored.
  - Separately, sequential fetch reaching pc=32'hFC -> delivers the 32'hFC instruction, then fault with fault_pc=32'h100.
- Asynchronous reset asserted mid-run (pc=32'h30, fetch_count=10): all outputs go to reset values without a clock edge. The first valid instruction appears 2 edges after release; fetch_count restarts at 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-fetch stage sitting in front of a combinational word-addressed
// instruction ROM. Holds the program counter, drives the ROM address, and
// captures the returned word into the IF/ID pipeline register. Handles
// stall, redirect (flush), and a sticky fault on illegal fetch addresses.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   rom_addr     ROM word address (pc[ADDR_W+1:2]), combinational
//   rom_dout     ROM instruction for rom_addr, same cycle
//   stall        decode cannot accept: hold pc and IF/ID
//   redirect     taken branch/jump this cycle (beats stall)
//   redirect_pc  byte target of the redirect
//   if_id_valid  IF/ID holds a real instruction
//   if_id_instr  fetched instruction
//   if_id_pc     byte address of if_id_instr
//   if_id_pc4    if_id_pc + 4 (link value)
//   pc           current fetch pc
//   fault        sticky fetch fault
//   fault_pc     offending byte address
//   fetch_count  saturating count of instructions delivered to IF/ID
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_dout,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc4,
    output logic [31:0]       pc,
    output logic              fault,
    output logic [31:0]       fault_pc,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // First byte address past the end of the ROM.
    localparam logic [31:0] ROM_BYTES = 32'd4 << ADDR_W;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ifpc_q, ifpc_d;
    logic [31:0]      ifpc4_q, ifpc4_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Set when the last ROM word has been delivered; the following edge
    // enters FAULT instead of letting pc run off the end of the ROM.
    logic             end_pend_q, end_pend_d;

    logic [31:0] pc_plus4;
    logic        redirect_bad;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        ifpc4_d      = ifpc4_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        count_d      = count_q;
        end_pend_d   = end_pend_q;
        pc_plus4     = pc_q + 32'd4;
        // Full 32-bit range check so high address bits cannot alias into the ROM.
        redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= ROM_BYTES);

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (end_pend_q) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_plus4;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                    end_pend_d = 1'b0;
                end else if (redirect) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (redirect_bad) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    instr_d = rom_dout;
                    ifpc_d  = pc_q;
                    ifpc4_d = pc_plus4;
                    valid_d = 1'b1;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (pc_plus4 >= ROM_BYTES) begin
                        end_pend_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            ifpc_q     <= 32'd0;
            ifpc4_q    <= 32'd0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
            count_q    <= '0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ifpc_q     <= ifpc_d;
            ifpc4_q    <= ifpc4_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            end_pend_q <= end_pend_d;
        end
    end

    assign rom_addr    = pc_q[ADDR_W+1:2];
    assign pc          = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_pc4   = ifpc4_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit against a behavioural ROM and compares every output
// after every edge with a reference model built from the fetch rules
// (boot cycle, redirect/stall/fetch priority, sticky fault). Directed
// sequences follow the test program; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          ADDR_W = 6;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_dout;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              if_id_valid;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc;
    logic [31:0]       if_id_pc4;
    logic [31:0]       pc;
    logic              fault;
    logic [31:0]       fault_pc;
    logic [CNT_W-1:0]  fetch_count;

    logic [31:0] rom [64];
    assign rom_dout = rom[rom_addr];

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .pc         (pc),
        .fault      (fault),
        .fault_pc   (fault_pc),
        .fetch_count(fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Reference model: what the fetch stage should look like after each edge.
    bit          m_booted;   // boot cycle already consumed since reset
    bit          m_at_end;   // last ROM word delivered, fault due next edge
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_fault_pc;
    bit          m_valid, m_fault;
    int          m_count;

    function automatic bit legal_target(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd256);
    endfunction

    task automatic model_reset();
        m_booted = 0; m_at_end = 0;
        m_pc = 0; m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0; m_fault_pc = 0;
        m_valid = 0; m_fault = 0; m_count = 0;
    endtask

    task automatic model_edge(input bit s, input bit r, input logic [31:0] rp);
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_fault) begin
            m_valid = 0;
        end else if (m_at_end) begin
            m_fault = 1; m_fault_pc = m_pc + 4; m_valid = 0; m_instr = NOP; m_at_end = 0;
        end else if (r) begin
            m_valid = 0; m_instr = NOP;
            if (legal_target(rp)) m_pc = rp;
            else begin m_fault = 1; m_fault_pc = rp; end
        end else if (!s) begin
            m_instr = rom[m_pc / 4];
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 4;
            m_valid = 1;
            if (m_count < 65535) m_count++;
            if (m_pc + 4 >= 256) m_at_end = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        check_eq("pc",          pc,                   m_pc);
        check_eq("rom_addr",    32'(rom_addr),        m_pc / 4);
        check_eq("if_id_valid", 32'(if_id_valid),     32'(m_valid));
        check_eq("if_id_instr", if_id_instr,          m_instr);
        check_eq("if_id_pc",    if_id_pc,             m_ifpc);
        check_eq("if_id_pc4",   if_id_pc4,            m_ifpc4);
        check_eq("fault",       32'(fault),           32'(m_fault));
        check_eq("fault_pc",    fault_pc,             m_fault_pc);
        check_eq("fetch_count", 32'(fetch_count),     32'(m_count));
    endtask

    // One clock: apply inputs, let the edge happen, compare on the falling edge.
    task automatic step(input bit s, input bit r, input logic [31:0] rp);
        stall = s; redirect = r; redirect_pc = rp;
        @(posedge clk);
        model_edge(s, r, rp);
        @(negedge clk);
        $display("edge stall=%0b redir=%0b rpc=%h -> pc=%h v=%0b instr=%h ifpc=%h flt=%0b cnt=%0d",
                 s, r, rp, pc, if_id_valid, if_id_instr, if_id_pc, fault, fetch_count);
        compare_all();
    endtask

    // Asynchronous reset mid-cycle; outputs are checked before any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] saved_count;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h0000_3f37;
        rom[1] = 32'h0200_0fe7;
        rom[8] = 32'h0000_1c63;
        rom[9] = 32'h042f_0293;

        rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Boot cycle then first two fetches.
        step(0, 0, 0);
        check_eq("boot_no_valid", 32'(if_id_valid), 32'd0);
        step(0, 0, 0);
        check_eq("tp_instr0", if_id_instr, 32'h0000_3f37);
        check_eq("tp_pc0",    if_id_pc,    32'h0);
        check_eq("tp_pc4_0",  if_id_pc4,   32'h4);
        step(0, 0, 0);
        check_eq("tp_instr1", if_id_instr, 32'h0200_0fe7);
        check_eq("tp_pc1",    if_id_pc,    32'h4);

        // Redirect to 0x20 while pc=8.
        check_eq("pre_redir_pc", pc, 32'h8);
        step(0, 1, 32'h20);
        check_eq("redir_flush_v", 32'(if_id_valid), 32'd0);
        check_eq("redir_pc",      pc,               32'h20);
        step(0, 0, 0);
        check_eq("redir_instr", if_id_instr, 32'h0000_1c63);
        check_eq("redir_ifpc4", if_id_pc4,   32'h24);

        // Three stall cycles at pc=0x24.
        saved_count = 32'(fetch_count);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check_eq("stall_pc",    pc,                32'h24);
            check_eq("stall_count", 32'(fetch_count),  saved_count);
            check_eq("stall_instr", if_id_instr,       32'h0000_1c63);
        end
        step(0, 0, 0);
        check_eq("unstall_instr", if_id_instr, 32'h042f_0293);
        check_eq("unstall_ifpc",  if_id_pc,    32'h24);

        // Redirect beats stall.
        step(1, 1, 32'h08);
        check_eq("redir_stall_pc", pc,               32'h8);
        check_eq("redir_stall_v",  32'(if_id_valid), 32'd0);

        // Randomized phase, mostly legal redirect targets.
        for (int i = 0; i < 200; i++) begin
            bit          s, r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 19) == 0) rp = $urandom;
            step(s, r, rp);
        end

        // Reach pc=0x30 with fetch_count=10, then reset asynchronously.
        @(negedge clk);
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'h10);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        check_eq("mid_pc",    pc,               32'h30);
        check_eq("mid_count", 32'(fetch_count), 32'd10);
        do_reset();
        check_eq("rst_count", 32'(fetch_count), 32'd0);
        step(0, 0, 0);
        check_eq("rst_boot_v", 32'(if_id_valid), 32'd0);
        step(0, 0, 0);
        check_eq("rst_first_v",   32'(if_id_valid), 32'd1);
        check_eq("rst_first_cnt", 32'(fetch_count), 32'd1);

        // Misaligned redirect faults; later stimulus ignored.
        step(0, 1, 32'h22);
        check_eq("flt_misal",    32'(fault), 32'd1);
        check_eq("flt_misal_pc", fault_pc,   32'h22);
        for (int i = 0; i < 10; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) * 4);
            check_eq("flt_frozen_v", 32'(if_id_valid), 32'd0);
        end

        // Aligned but out-of-range redirect faults.
        @(negedge clk);
        do_reset();
        step(0, 0, 0);
        step(0, 1, 32'h100);
        check_eq("flt_range_pc", fault_pc, 32'h100);

        // Sequential fetch off the end of the ROM.
        @(negedge clk);
        do_reset();
        step(0, 0, 0);
        step(0, 1, 32'hF0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check_eq("end_instr", if_id_instr,      rom[63]);
        check_eq("end_ifpc",  if_id_pc,         32'hFC);
        check_eq("end_nofault", 32'(fault),     32'd0);
        step(0, 0, 0);
        check_eq("end_fault",    32'(fault),       32'd1);
        check_eq("end_fault_pc", fault_pc,         32'h100);
        check_eq("end_valid",    32'(if_id_valid), 32'd0);
        step(0, 1, 32'h0);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
